// File: rtl/ex_alu_stage.sv
// ex_alu_stage: registered execute stage of the 64-bit datapath.
// Takes one decoded op per cycle over a valid/ready handshake, computes the
// ALU function combinationally and holds {result, zero, ovf, tag} in a single
// output register that the writeback/branch stage drains with out_ready.
//
// Ports:
//   clk, rst_n           rising-edge clock, async active-low reset
//   in_valid / in_ready  input handshake
//   in_op, in_a, in_b    opcode and operands (SRA amount is in_b[5:0])
//   in_tag               tag carried unchanged to the output
//   flush                kills the held result and blocks this cycle's input
//   out_valid/out_ready  output handshake
//   out_result, out_zero, out_ovf, out_tag   held result fields
module ex_alu_stage #(
  parameter int W     = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_result,
  output logic             out_zero,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_SLT  = 3'b101;
  localparam logic [2:0] OP_SLTU = 3'b110;
  localparam logic [2:0] OP_SRA  = 3'b111;

  typedef struct packed {
    logic [W-1:0]     result;
    logic             zero;
    logic             ovf;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  logic [W-1:0] sum, diff, res;
  logic         ovf;
  logic         accept;
  rsp_t         rsp_d, rsp_q;
  logic         vld_q;

  assign sum  = in_a + in_b;
  assign diff = in_a - in_b;

  // Overflow is only meaningful for ADD/SUB: operands of matching (ADD) or
  // opposite (SUB) sign producing a result whose sign differs from a.
  always_comb begin
    res = '0;
    ovf = 1'b0;
    case (in_op)
      OP_ADD: begin
        res = sum;
        ovf = (in_a[W-1] == in_b[W-1]) && (sum[W-1] != in_a[W-1]);
      end
      OP_SUB: begin
        res = diff;
        ovf = (in_a[W-1] != in_b[W-1]) && (diff[W-1] != in_a[W-1]);
      end
      OP_AND:  res = in_a & in_b;
      OP_OR:   res = in_a | in_b;
      OP_XOR:  res = in_a ^ in_b;
      OP_SLT:  res = {{(W-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU: res = {{(W-1){1'b0}}, (in_a < in_b)};
      OP_SRA:  res = $signed(in_a) >>> in_b[5:0];
      default: res = '0;
    endcase
  end

  assign rsp_d = '{result: res, zero: (res == '0), ovf: ovf, tag: in_tag};

  // Ready is independent of in_valid/in_* so upstream sees no comb loop.
  assign in_ready = !flush && (!vld_q || out_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      rsp_q <= '0;
    end else begin
      // flush beats accept (in_ready is already 0) and consume
      if (flush)          vld_q <= 1'b0;
      else if (accept)    vld_q <= 1'b1;
      else if (out_ready) vld_q <= 1'b0;
      // data only moves on accept, so a stall keeps the fields bit-stable
      if (accept) rsp_q <= rsp_d;
    end
  end

  assign out_valid  = vld_q;
  assign out_result = rsp_q.result;
  assign out_zero   = rsp_q.zero;
  assign out_ovf    = rsp_q.ovf;
  assign out_tag    = rsp_q.tag;

endmodule

// File: tb/tb_ex_alu_stage.sv
// Bench for ex_alu_stage: directed spec scenarios plus a randomized phase,
// all checked against a small reference model of the stage.
module tb_ex_alu_stage;

  logic        clk, rst_n;
  logic        in_valid, in_ready;
  logic [2:0]  in_op;
  logic [63:0] in_a, in_b;
  logic [4:0]  in_tag;
  logic        flush;
  logic        out_valid, out_ready;
  logic [63:0] out_result;
  logic        out_zero, out_ovf;
  logic [4:0]  out_tag;

  int errors = 0;
  int checks = 0;

  // reference state: one held entry
  bit          mvalid;
  logic [63:0] mres;
  bit          movf;
  logic [4:0]  mtag;
  logic [4:0]  drained[$];

  ex_alu_stage #(.W(64), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_zero(out_zero), .out_ovf(out_ovf),
    .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    longint sa, sb;
    sa = a; sb = b;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return (sa < sb) ? 64'd1 : 64'd0;
      3'd6: return (a < b) ? 64'd1 : 64'd0;
      default: return sa >>> b[5:0];
    endcase
  endfunction

  // overflow = exact 65-bit signed result does not fit in 64 bits
  function automatic bit ref_ovf(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [64:0] w;
    if (op == 3'd0)      w = {a[63], a} + {b[63], b};
    else if (op == 3'd1) w = {a[63], a} - {b[63], b};
    else return 1'b0;
    return w[64] != w[63];
  endfunction

  function automatic logic [63:0] rnd64();
    case ($urandom_range(0, 7))
      0: return 64'h7FFF_FFFF_FFFF_FFFF;
      1: return 64'h8000_0000_0000_0000;
      2: return '1;
      3: return 64'd0;
      4: return 64'($urandom_range(0, 70));
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // One clock: check ready, step the model across the edge, check outputs.
  task automatic cyc(output bit acc);
    bit exp_rdy;
    #1;
    exp_rdy = !flush && (!mvalid || out_ready);
    chk("in_ready", 64'(in_ready), 64'(exp_rdy));
    acc = in_valid && exp_rdy;
    if (mvalid && out_ready && !flush) drained.push_back(mtag);
    @(posedge clk);
    if (flush) mvalid = 0;
    else if (acc) begin
      mvalid = 1;
      mres   = ref_res(in_op, in_a, in_b);
      movf   = ref_ovf(in_op, in_a, in_b);
      mtag   = in_tag;
    end else if (out_ready) mvalid = 0;
    #1;
    chk("out_valid", 64'(out_valid), 64'(mvalid));
    if (mvalid) begin
      chk("out_result", out_result, mres);
      chk("out_zero", 64'(out_zero), 64'(mres == 64'd0));
      chk("out_ovf", 64'(out_ovf), 64'(movf));
      chk("out_tag", 64'(out_tag), 64'(mtag));
    end
  endtask

  // Directed op with spec-given expected result and overflow.
  task automatic do_op(input string name, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] er, input bit eo);
    bit acc;
    in_valid = 1; in_op = op; in_a = a; in_b = b; in_tag = in_tag + 5'd1;
    cyc(acc);
    in_valid = 0;
    chk({name, "_res"}, out_result, er);
    chk({name, "_ovf"}, 64'(out_ovf), 64'(eo));
    chk({name, "_vld"}, 64'(out_valid), 64'd1);
  endtask

  initial begin
    bit acc;
    int k;
    rst_n = 0; in_valid = 0; in_op = 0; in_a = 0; in_b = 0; in_tag = 0;
    flush = 0; out_ready = 1;
    mvalid = 0; mres = 0; movf = 0; mtag = 0;
    #2;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_result", out_result, 64'd0);
    chk("rst_flags", {62'd0, out_zero, out_ovf}, 64'd0);
    chk("rst_tag", 64'(out_tag), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #3; rst_n = 1;

    // ADD and zero flag
    do_op("add30", 3'd0, 64'd10, 64'd20, 64'd30, 0);
    chk("add30_zero", 64'(out_zero), 64'd0);
    do_op("add0", 3'd0, 64'd5, -64'sd5, 64'd0, 0);
    chk("add0_zero", 64'(out_zero), 64'd1);

    // compares
    do_op("slt_a", 3'd5, -64'sd10, 64'd5, 64'd1, 0);
    do_op("slt_b", 3'd5, -64'sd5, -64'sd10, 64'd0, 0);
    do_op("slt_eq", 3'd5, -64'sd20, -64'sd20, 64'd0, 0);
    do_op("sltu", 3'd6, -64'sd10, 64'd5, 64'd0, 0);
    do_op("slt_c", 3'd5, 64'd16, 64'd15, 64'd0, 0);

    // overflow and shift
    do_op("sub_ovf", 3'd1, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1);
    do_op("add_ovf", 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1);
    do_op("sra", 3'd7, -64'sd64, 64'h43, -64'sd8, 0);
    do_op("xor", 3'd4, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, '1, 0);
    cyc(acc);
    chk("drain_idle", 64'(out_valid), 64'd0);

    // back-pressure: 4 ADDs, out_ready low for 3 cycles after first accept
    drained.delete();
    k = 1;
    for (int c = 0; c < 20 && k <= 4; c++) begin
      out_ready = (c >= 4);
      in_valid = 1; in_op = 3'd0; in_a = 64'(k * 100); in_b = 64'(k); in_tag = 5'(k);
      cyc(acc);
      if (acc) k++;
      if (c >= 1 && c <= 3) chk("stall_tag", 64'(out_tag), 64'd1);
    end
    in_valid = 0;
    cyc(acc);
    chk("bp_count", 64'(drained.size()), 64'd4);
    for (int i = 0; i < 4; i++)
      chk("bp_order", 64'(i < drained.size() ? drained[i] : 5'd0), 64'(i + 1));

    // flush while stalled, flushed input must never surface
    drained.delete();
    out_ready = 0;
    in_valid = 1; in_op = 3'd0; in_a = 64'd1; in_b = 64'd2; in_tag = 5'd5;
    cyc(acc);
    in_valid = 0;
    cyc(acc);
    flush = 1; in_valid = 1; in_tag = 5'd6; in_a = 64'd99;
    cyc(acc);
    chk("flush_vld", 64'(out_valid), 64'd0);
    flush = 0; out_ready = 1; in_tag = 5'd7; in_a = 64'd3; in_b = 64'd4;
    cyc(acc);
    in_valid = 0;
    chk("post_flush_tag", 64'(out_tag), 64'd7);
    chk("post_flush_res", out_result, 64'd7);
    cyc(acc);
    chk("flush_drained", 64'(drained.size()), 64'd1);
    chk("flush_tag", 64'(drained.size() > 0 ? drained[0] : 5'd0), 64'd7);

    // randomized mix
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_op     = 3'($urandom_range(0, 7));
      in_a      = rnd64();
      in_b      = rnd64();
      in_tag    = 5'($urandom);
      cyc(acc);
    end
    flush = 0; in_valid = 0; out_ready = 1;
    cyc(acc);

    // async reset while stalled holding a result
    out_ready = 0;
    in_valid = 1; in_op = 3'd2; in_a = '1; in_b = 64'hF0; in_tag = 5'd9;
    cyc(acc);
    in_valid = 0;
    chk("pre_rst_vld", 64'(out_valid), 64'd1);
    #2; rst_n = 0; mvalid = 0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_result", out_result, 64'd0);
    chk("mid_rst_flags", {62'd0, out_zero, out_ovf}, 64'd0);
    chk("mid_rst_tag", 64'(out_tag), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    #2; rst_n = 1;
    out_ready = 1;
    in_valid = 1; in_op = 3'd0; in_a = 64'd1; in_b = 64'd1; in_tag = 5'd3;
    cyc(acc);
    in_valid = 0;
    chk("post_rst_res", out_result, 64'd2);
    chk("post_rst_vld", 64'(out_valid), 64'd1);
    cyc(acc);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
